// File: rtl/calc_sequencer_if.sv
// Tile pin bundle for the calculator sequencer: 8 inputs in, 8 display outputs out.
interface calc_sequencer_if;
   logic [7:0] io_in;
   logic [7:0] io_out;

   modport master (output io_in, input io_out);
   modport slave  (input io_in, output io_out);
endinterface

// File: rtl/calc_sequencer.sv
// Stepped operand/opcode entry sequencer for the 4-bit calculator tile.
// A, B and an opcode are keyed in on the data nibble, one per strobe press.
// The result is computed in one cycle and held on the 7-segment display.
module calc_sequencer #(
   parameter int SYNC_STAGES = 2
) (
   input logic             clk,
   input logic             rst_n,
   calc_sequencer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ENT_A, ENT_B, ENT_OP, EXEC, SHOW} state_t;

   state_t state_reg, state_next;

   logic [SYNC_STAGES-1:0] strb_sync_reg, clr_sync_reg;
   logic                   strb_d_reg;
   logic                   strb_p, clr;

   logic [3:0] a_reg, a_next;
   logic [3:0] b_reg, b_next;
   logic [1:0] op_reg, op_next;
   logic [3:0] res_reg, res_next;
   logic       flag_reg, flag_next;

   logic [3:0] alu_res;
   logic       alu_flag;
   logic [4:0] sum;

   // Clock and reset arrive on io_in[1:0] but are consumed through the scalar ports.
   logic unused_pins;
   assign unused_pins = &{1'b0, bus.io_in[1:0]};

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   // Synchronize strobe and clear; keep one extra strobe flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strb_sync_reg <= '0;
         clr_sync_reg  <= '0;
         strb_d_reg    <= 1'b0;
      end else begin
         strb_sync_reg <= {strb_sync_reg[SYNC_STAGES-2:0], bus.io_in[2]};
         clr_sync_reg  <= {clr_sync_reg[SYNC_STAGES-2:0], bus.io_in[3]};
         strb_d_reg    <= strb_sync_reg[SYNC_STAGES-1];
      end
   end

   assign strb_p = strb_sync_reg[SYNC_STAGES-1] & ~strb_d_reg;
   assign clr    = clr_sync_reg[SYNC_STAGES-1];

   // Single-cycle ALU on the latched operands.
   always_comb begin
      sum      = {1'b0, a_reg} + {1'b0, b_reg};
      alu_res  = 4'h0;
      alu_flag = 1'b0;
      case (op_reg)
         2'd0: begin
            alu_res  = sum[3:0];
            alu_flag = sum[4];
         end
         2'd1: begin
            alu_res  = a_reg - b_reg;
            alu_flag = (a_reg < b_reg);
         end
         2'd2: begin
            alu_res  = a_reg & b_reg;
            alu_flag = ((a_reg & b_reg) == 4'h0);
         end
         default: begin
            alu_res  = (a_reg < b_reg) ? 4'd0 : ((a_reg == b_reg) ? 4'd1 : 4'd2);
            alu_flag = 1'b0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= 4'h0;
         b_reg     <= 4'h0;
         op_reg    <= 2'd0;
         res_reg   <= 4'h0;
         flag_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         op_reg    <= op_next;
         res_reg   <= res_next;
         flag_reg  <= flag_next;
      end
   end

   // Next-state and register-load logic; clear wins over a coincident strobe pulse.
   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      op_next    = op_reg;
      res_next   = res_reg;
      flag_next  = flag_reg;
      if (clr) begin
         state_next = IDLE;
         a_next     = 4'h0;
         b_next     = 4'h0;
         op_next    = 2'd0;
         res_next   = 4'h0;
         flag_next  = 1'b0;
      end else begin
         case (state_reg)
            IDLE:   if (strb_p) state_next = ENT_A;
            ENT_A:  if (strb_p) begin a_next  = bus.io_in[7:4]; state_next = ENT_B;  end
            ENT_B:  if (strb_p) begin b_next  = bus.io_in[7:4]; state_next = ENT_OP; end
            ENT_OP: if (strb_p) begin op_next = bus.io_in[5:4]; state_next = EXEC;   end
            EXEC: begin
               res_next   = alu_res;
               flag_next  = alu_flag;
               state_next = SHOW;
            end
            SHOW:   if (strb_p) state_next = ENT_A;
            default: state_next = IDLE;
         endcase
      end
   end

   // Display: live data while entering, result in SHOW, dash when idle, blank in EXEC.
   always_comb begin
      bus.io_out = 8'h40;
      case (state_reg)
         IDLE:         bus.io_out = 8'h40;
         ENT_A, ENT_B: bus.io_out = {1'b1, hex7(bus.io_in[7:4])};
         ENT_OP:       bus.io_out = {1'b1, hex7({2'b00, bus.io_in[5:4]})};
         EXEC:         bus.io_out = 8'h00;
         SHOW:         bus.io_out = {flag_reg, hex7(res_reg)};
         default:      bus.io_out = 8'h40;
      endcase
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus pushes expected SHOW displays,
// a monitor pops them when it sees the one-cycle EXEC blank followed by SHOW.
module tb_calc_sequencer;

   logic       clk;
   logic       rst_n;
   logic       strobe;
   logic       clear;
   logic [3:0] data;

   int n_checks;
   int n_fail;

   logic [7:0] exp_q[$];
   string      name_q[$];
   logic       got_exec;

   calc_sequencer_if bus ();

   assign bus.io_in = {data, clear, strobe, rst_n, clk};

   calc_sequencer #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: io_out=%h required=%h", name, got, exp);
      end else begin
         $display("ok   %s: io_out=%h", name, got);
      end
   endtask

   // Monitor: EXEC shows 0x00 (never shown elsewhere); the next sample is the result.
   always @(negedge clk) begin
      if (!rst_n) begin
         got_exec = 1'b0;
      end else if (bus.io_out == 8'h00) begin
         got_exec = 1'b1;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_exec: io_out=%h required=no EXEC", bus.io_out);
         end
      end else if (got_exec) begin
         got_exec = 1'b0;
         if (exp_q.size() != 0) begin
            check({"show_", name_q.pop_front()}, bus.io_out, exp_q.pop_front());
         end
      end
   end

   // One strobe press: high for 3 edges (step lands on the 3rd), then low for 2.
   task automatic pulse(input logic [3:0] d);
      data   = d;
      strobe = 1'b1;
      repeat (3) @(posedge clk);
      #1 strobe = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Full calculation from IDLE or SHOW.
   task automatic run_calc(input string name, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, input logic [7:0] exp);
      exp_q.push_back(exp);
      name_q.push_back(name);
      pulse(a);
      pulse(a);
      pulse(b);
      pulse({2'b00, op});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      got_exec = 1'b0;
      rst_n    = 1'b0;
      strobe   = 1'b0;
      clear    = 1'b0;
      data     = 4'h0;
      repeat (3) @(posedge clk);
      @(negedge clk) check("reset_dash", bus.io_out, 8'h40);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk) check("idle_after_reset", bus.io_out, 8'h40);
      @(posedge clk);
      #1;

      // 9 + 8 = 17 -> 1 with carry; also checks entry displays along the way.
      exp_q.push_back(8'h86);
      name_q.push_back("add_9_8");
      pulse(4'h0);
      data = 4'h5;
      @(negedge clk) check("ent_a_live_5", bus.io_out, 8'hED);
      @(posedge clk);
      #1;
      pulse(4'h9);
      pulse(4'h8);
      data = 4'hE;
      @(negedge clk) check("ent_op_bits54", bus.io_out, 8'hDB);
      @(posedge clk);
      #1;
      pulse(4'h0);

      run_calc("sub_3_5",  4'h3, 4'h5, 2'd1, 8'hF9);
      run_calc("cmp_6_6",  4'h6, 4'h6, 2'd3, 8'h06);
      run_calc("and_c_3",  4'hC, 4'h3, 2'd2, 8'hBF);
      run_calc("add_a_5",  4'hA, 4'h5, 2'd0, 8'h71);
      run_calc("sub_7_2",  4'h7, 4'h2, 2'd1, 8'h6D);
      run_calc("cmp_5_9",  4'h5, 4'h9, 2'd3, 8'h3F);
      run_calc("cmp_9_7",  4'h9, 4'h7, 2'd3, 8'h5B);
      run_calc("and_6_3",  4'h6, 4'h3, 2'd2, 8'h5B);

      // Strobe held for 20 cycles in ENT_A gives exactly one step.
      pulse(4'h1);
      @(negedge clk) check("ent_a_live_1", bus.io_out, 8'h86);
      @(posedge clk);
      #1;
      data   = 4'hF;
      strobe = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk) check("held_one_step", bus.io_out, 8'hF1);
      @(posedge clk);
      #1 strobe = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pulse(4'hF);
      @(negedge clk) check("held_then_ent_op", bus.io_out, 8'hCF);
      @(posedge clk);
      #1;
      exp_q.push_back(8'hF9);
      name_q.push_back("add_f_f");
      pulse(4'h0);

      // Latency: strobe raised after edge e0 takes effect at e3 (sampled at e1).
      data   = 4'h3;
      strobe = 1'b1;
      @(posedge clk);
      @(negedge clk) check("lat_e1_hold", bus.io_out, 8'hF9);
      @(posedge clk);
      @(negedge clk) check("lat_e2_hold", bus.io_out, 8'hF9);
      @(posedge clk);
      @(negedge clk) check("lat_e3_step", bus.io_out, 8'hCF);
      @(posedge clk);
      #1 strobe = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(8'h6D);
      name_q.push_back("sub_7_2_after_lat");
      pulse(4'h7);
      pulse(4'h2);
      pulse(4'h1);

      // Clear and strobe together in ENT_OP: back to IDLE, no EXEC.
      pulse(4'h1);
      pulse(4'h2);
      pulse(4'h3);
      data   = 4'h0;
      clear  = 1'b1;
      strobe = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk) check("clear_to_idle", bus.io_out, 8'h40);
      @(posedge clk);
      #1;
      clear  = 1'b0;
      strobe = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk) check("idle_after_clear", bus.io_out, 8'h40);
      @(posedge clk);
      #1;
      run_calc("add_0_0_after_clear", 4'h0, 4'h0, 2'd0, 8'h3F);

      // Asynchronous reset mid ENT_B.
      pulse(4'h4);
      pulse(4'h4);
      data = 4'h7;
      @(posedge clk);
      #3 check("ent_b_live_7", bus.io_out, 8'h87);
      rst_n = 1'b0;
      #1 check("async_reset_dash", bus.io_out, 8'h40);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk) check("idle_after_async", bus.io_out, 8'h40);
      @(posedge clk);
      #1;
      run_calc("add_2_3_after_reset", 4'h2, 4'h3, 2'd0, 8'h6D);

      repeat (5) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Clocked operand/opcode entry sequencer for the 4-bit calculator tile with a 7-segment display.
- The user keys operand A, operand B and an opcode in turn on a shared data nibble, using a debounced strobe to step through.
- The block latches each value, executes the operation in one cycle, and holds the result on the display until the next strobe.
- It replaces direct combinational operand wiring with a registered, stepped sequence, all on the standard 8-in/8-out tile pinout.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on the strobe and clear inputs (minimum 2).

Ports:
- io_in[0]  input  1  clock (clk), all flops on the rising edge.
- io_in[1]  input  1  rst_n; one clock; reset is asynchronous and active-low.
- io_in[2]  input  1  strobe; a level button, rising edge advances the sequence.
- io_in[3]  input  1  clear; level, synchronized, returns the block to IDLE.
- io_in[7:4]  input  4  data nibble: operand value, or opcode in bits [5:4].
- io_out[6:0]  output  7  segments a..g (bit0=a), active-high.
- io_out[7]  output  1  decimal point: entry indicator, or result flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE; A, B, OP, RES, FLAG = 0; synchronizer flops = 0.
  - Outputs io_out[6:0]=0x40 (dash), io_out[7]=0.
- Synchronizers and pulses:
  - strobe and clear each pass through SYNC_STAGES flops.
  - strb_p = sync_out & ~sync_out_d (single-cycle pulse).
  - clr = synchronized clear level.
- Timing: with SYNC_STAGES=2, strobe first sampled high at edge k takes effect (state/register update) at edge k+2. Holding strobe high produces exactly one step; a new step needs strobe low for at least 1 sampled cycle first.
- FSM states: IDLE, ENT_A, ENT_B, ENT_OP, EXEC, SHOW.
  - IDLE, strb_p -> ENT_A.
  - ENT_A, strb_p -> A <= io_in[7:4], go ENT_B.
  - ENT_B, strb_p -> B <= io_in[7:4], go ENT_OP.
  - ENT_OP, strb_p -> OP <= io_in[5:4], go EXEC.
  - EXEC -> SHOW unconditionally after 1 cycle; RES and FLAG are registered on this edge.
  - SHOW, strb_p -> ENT_A; A, B, OP, RES and FLAG are retained until overwritten.
- clr high at any edge -> IDLE with A, B, OP, RES, FLAG = 0. clr has priority over strb_p; a pulse coincident with clr is discarded.
- Operations (4-bit, unsigned):
  - OP=0 add: RES = (A+B) mod 16, FLAG = carry out.
  - OP=1 sub: RES = (A-B) mod 16, FLAG = 1 iff A<B.
  - OP=2 and: RES = A & B, FLAG = (RES==0).
  - OP=3 cmp: RES = 0 if A<B, 1 if A==B, 2 if A>B; FLAG = 0.
- Display (combinational from state/registers, live data in entry states):
  - IDLE: segments 0x40, dp 0.
  - ENT_A, ENT_B: hex of io_in[7:4], dp 1.
  - ENT_OP: hex of {2'b00, io_in[5:4]}, dp 1.
  - EXEC: segments 0x00, dp 0.
  - SHOW: hex of RES, dp = FLAG.
- Hex encoding: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Reset mid-sequence: immediate return to IDLE values regardless of state; no partial latch survives.
- No X on outputs for any input combination after reset.

Test Plan:
- Reset with rst_n low mid-ENT_B -> io_out = 0x40 asynchronously (before next clk edge); state IDLE.
- Steps (strobe pulses): strobe; data=9 strobe; data=8 strobe; data op=0 strobe -> after EXEC, io_out[6:0]=0x06 (1), io_out[7]=1 (carry, 9+8=17).
- A=3, B=5, op=1 -> RES=E, segments 0x79, dp 1 (borrow).
- A=6, B=6, op=3 -> RES=1, segments 0x06, dp 0; then A=C, B=3, op=2 -> RES=0, segments 0x3F, dp 1.
- Strobe held high for 20 cycles in ENT_A -> exactly one advance to ENT_B; strobe asserted 1 cycle after being low -> no step until 2 edges later.
- clear and strobe rising on the same cycle in ENT_OP -> IDLE, io_out=0x40, no EXEC; registers read back 0 via SHOW path after a full 0+0 add (segments 0x3F, dp 0).
